// File: rtl/mat_mult_seq.sv
// Sequential signed matrix multiplier: C = A x B for square matrices of dimension 1..N,
// one multiply-accumulate per cycle, per-element saturation and a sticky overflow flag.
module mat_mult_seq #(
  parameter int N    = 5,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW + $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        size,
  input  logic [N*N*DW-1:0] mat_a,
  input  logic [N*N*DW-1:0] mat_b,
  output logic [N*N*DW-1:0] mat_c,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  // Handshake: start is sampled only in IDLE; busy is high from the accepting edge
  // until DONE is entered; done pulses for exactly one cycle while busy is low.

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2**(DW-1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  state_t                   state, state_nx;
  logic [N*N*DW-1:0]        a_q, b_q;
  logic [2:0]               sz_q, sz_in;
  logic [2:0]               i, j, k;
  logic signed [ACCW-1:0]   acc;
  logic signed [DW-1:0]     a_el, b_el;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic [DW-1:0]            sat_el;
  logic                     clip;
  logic                     k_last, j_last, el_last;

  // Bit offset of element (r,c); element (0,0) sits in the MSBs.
  function automatic int elem_pos(input logic [2:0] r, input logic [2:0] c);
    return ((N*N - 1) - (int'(r)*N + int'(c))) * DW;
  endfunction

  assign sz_in     = (size == 3'd0 || int'(size) > N) ? 3'(N) : size;
  assign dbg_state = state;

  assign a_el     = a_q[elem_pos(i, k) +: DW];
  assign b_el     = b_q[elem_pos(k, j) +: DW];
  assign prod     = a_el * b_el;
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

  assign k_last  = (k == sz_q - 3'd1);
  assign j_last  = (j == sz_q - 3'd1);
  assign el_last = j_last && (i == sz_q - 3'd1);

  always_comb begin
    sat_el = acc[DW-1:0];
    clip   = 1'b0;
    if (acc > SAT_MAX) begin
      sat_el = SAT_MAX[DW-1:0];
      clip   = 1'b1;
    end else if (acc < SAT_MIN) begin
      sat_el = SAT_MIN[DW-1:0];
      clip   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (k_last) state_nx = WRITE;
      WRITE:   state_nx = el_last ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sz_q  <= '0;
      mat_c <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= mat_a;
            b_q   <= mat_b;
            sz_q  <= sz_in;
            mat_c <= '0;
            ovf   <= 1'b0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 3'd1;
        end
        WRITE: begin
          mat_c[elem_pos(i, j) +: DW] <= sat_el;
          if (clip) ovf <= 1'b1;
          acc <= '0;
          k   <= '0;
          // i stays on the last row after the final element so indices remain in range.
          if (j_last) begin
            j <= '0;
            if (!el_last) i <= i + 3'd1;
          end else begin
            j <= j + 3'd1;
          end
          if (el_last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
